// File: rtl/nanov_shift_pkg.sv
// Shared types and the op/rot decode for the nanoV digit-serial shifter.
// Rotate decode is only reachable when NANOV_SHIFT_ROTATE_EN is defined (rot gated in the top).
package nanov_shift_pkg;

   typedef enum logic [2:0] {
      SH_SLL,
      SH_SRL,
      SH_SRA,
      SH_ROL,
      SH_ROR
   } sh_mode_t;

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } sh_state_t;

   localparam int OP_RIGHT_BIT = 2;
   localparam int OP_ARITH_BIT = 3;

   // op[1:0] carries funct3 bits that do not affect the shift kind
   function automatic sh_mode_t op_to_mode(input logic [3:0] op, input logic rot);
      sh_mode_t m;
      if (rot) begin
         m = op[OP_RIGHT_BIT] ? SH_ROR : SH_ROL;
      end else if (!op[OP_RIGHT_BIT]) begin
         m = SH_SLL;
      end else if (op[OP_ARITH_BIT]) begin
         m = SH_SRA;
      end else begin
         m = SH_SRL;
      end
      return m;
   endfunction

endpackage

// File: rtl/nanov_shift_digit.sv
// Combinational digit generator: produces result bits [k*DW +: DW] of the latched shift.
// Wrap (rotate) selection exists only when NANOV_SHIFT_ROTATE_EN is defined.
module nanov_shift_digit
   import nanov_shift_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int DW = 4,
   localparam int SHW = $clog2(XLEN),
   localparam int KW = $clog2(XLEN / DW)
) (
   input  logic [XLEN-1:0] a,
   input  logic [SHW-1:0]  b,
   input  sh_mode_t        mode,
   input  logic [KW-1:0]   k,
   output logic [DW-1:0]   digit
);

   localparam int LDW = $clog2(DW);

   for (genvar gi = 0; gi < DW; gi++) begin : g_bit
      localparam logic [SHW:0] I_OFF = (SHW + 1)'(gi);
      logic [SHW:0] j;
      logic [SHW:0] up;
      logic [SHW:0] dn;
      logic         bit_v;

      // The extra MSB of up/dn flags overflow/borrow; the low SHW bits are the mod-XLEN index
      always_comb begin
         j  = ((SHW + 1)'(k) << LDW) | I_OFF;
         up = j + {1'b0, b};
         dn = j - {1'b0, b};
         bit_v = 1'b0;
         case (mode)
            SH_SLL: bit_v = dn[SHW] ? 1'b0 : a[dn[SHW-1:0]];
            SH_SRL: bit_v = up[SHW] ? 1'b0 : a[up[SHW-1:0]];
            SH_SRA: bit_v = up[SHW] ? a[XLEN-1] : a[up[SHW-1:0]];
`ifdef NANOV_SHIFT_ROTATE_EN
            SH_ROL: bit_v = a[dn[SHW-1:0]];
            SH_ROR: bit_v = a[up[SHW-1:0]];
`endif
            default: bit_v = 1'b0;
         endcase
      end

      assign digit[gi] = bit_v;
   end

endmodule

// File: rtl/nanov_digit_shift.sv
// Digit-serial shifter top: latches a request, streams the result LSB-first as DW-bit digits.
// Optional rotate support is enabled by defining NANOV_SHIFT_ROTATE_EN.
//
// state   | meaning
// --------|------------------------------------------------------------
// ST_IDLE | waiting for a request; in_ready=1
// ST_RUN  | emitting digit cnt; out_valid=1, returns on last transfer
module nanov_digit_shift
   import nanov_shift_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int DW = 4,
   localparam int SHW = $clog2(XLEN)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [3:0]      op,
   input  logic            rot,
   input  logic [XLEN-1:0] a,
   input  logic [SHW-1:0]  b,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [DW-1:0]   out_data,
   output logic            out_last
);

   localparam int NDIG = XLEN / DW;
   localparam int KW = $clog2(NDIG);
   localparam logic [KW-1:0] K_LAST = KW'(NDIG - 1);

   sh_state_t       state;
   sh_state_t       state_nxt;
   logic [KW-1:0]   cnt;
   logic [XLEN-1:0] a_q;
   logic [SHW-1:0]  b_q;
   sh_mode_t        mode_q;
   logic            rot_eff;
   logic            accept;
   logic            xfer;

`ifdef NANOV_SHIFT_ROTATE_EN
   assign rot_eff = rot;
`else
   logic unused_rot;
   assign unused_rot = rot;
   assign rot_eff    = 1'b0;
`endif

   assign accept = in_valid && in_ready;
   assign xfer   = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            cnt <= '0;
         end else if (xfer) begin
            cnt <= out_last ? '0 : cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_q    <= '0;
         b_q    <= '0;
         mode_q <= SH_SLL;
      end else if (accept) begin
         a_q    <= a;
         b_q    <= b;
         mode_q <= op_to_mode(op, rot_eff);
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (accept) state_nxt = ST_RUN;
         ST_RUN:  if (xfer && out_last && !accept) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state == ST_RUN);
      out_last  = out_valid && (cnt == K_LAST);
      in_ready  = (state == ST_IDLE) || (out_valid && out_ready && out_last);
   end

   nanov_shift_digit #(
      .XLEN(XLEN),
      .DW  (DW)
   ) u_digit (
      .a    (a_q),
      .b    (b_q),
      .mode (mode_q),
      .k    (cnt),
      .digit(out_data)
   );

endmodule

// File: tb/tb_nanov_digit_shift.sv
// Self-checking bench for nanov_digit_shift (XLEN=32, DW=4) against a word-level shift model.
// Rotate expectations follow NANOV_SHIFT_ROTATE_EN as compiled.
module tb_nanov_digit_shift;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [3:0]  op = '0;
   logic        rot = 1'b0;
   logic [31:0] a = '0;
   logic [4:0]  b = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [3:0]  out_data;
   logic        out_last;

   int checks = 0;
   int errors = 0;

   nanov_digit_shift #(.XLEN(32), .DW(4)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .op       (op),
      .rot      (rot),
      .a        (a),
      .b        (b),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .out_data (out_data),
      .out_last (out_last)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_word(input logic [3:0] o, input logic r,
                                            input logic [31:0] av, input logic [4:0] bv);
      int sh;
      logic rr;
      sh = int'(bv);
`ifdef NANOV_SHIFT_ROTATE_EN
      rr = r;
`else
      rr = 1'b0 & r;
`endif
      if (rr && o[2])      return (av >> sh) | (av << (32 - sh));
      else if (rr)         return (av << sh) | (av >> (32 - sh));
      else if (!o[2])      return av << sh;
      else if (o[3])       return 32'($signed(av) >>> sh);
      else                 return av >> sh;
   endfunction

   task automatic start_req(input logic [3:0] o, input logic r, input logic [31:0] av,
                            input logic [4:0] bv);
      int w = 0;
      op = o; rot = r; a = av; b = bv; in_valid = 1'b1;
      while (!in_ready && w < 100) begin
         @(posedge clk); #1; w++;
      end
      checks++;
      if (in_ready !== 1'b1) begin
         errors++;
         $display("FAIL start_wait in_ready=%0b required=1", in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      op = 4'($urandom); rot = 1'($urandom); a = $urandom; b = 5'($urandom);
   endtask

   task automatic collect(input int k0, input int k1, input bit stall,
                          inout logic [31:0] word, inout logic [7:0] lastv,
                          output int lat, output bit to);
      int k = k0;
      lat = 0; to = 1'b0;
      while (k < k1) begin
         out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
         if (out_valid && out_ready) begin
            word[k*4 +: 4] = out_data;
            lastv[k] = out_last;
            k++;
         end
         @(posedge clk); #1; lat++;
         if (lat > 400) begin
            to = 1'b1;
            break;
         end
      end
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%0b exp=0", out_valid); end
      checks++;
      if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last got=%0b exp=0", out_last); end
      rst = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%0b exp=1", in_ready); end
   endtask

   task automatic test_sll_vector();
      logic [31:0] w = '0;
      logic [7:0]  lv = '0;
      int lat; bit to;
      start_req(4'b0001, 1'b0, 32'h8000_0001, 5'd4);
      collect(0, 8, 1'b0, w, lv, lat, to);
      checks++;
      if (to || w !== 32'h0000_0010) begin errors++; $display("FAIL sll_word got=%h exp=00000010 to=%0b", w, to); end
      checks++;
      if (lv !== 8'h80) begin errors++; $display("FAIL sll_last got=%b exp=10000000", lv); end
      checks++;
      if (lat !== 8) begin errors++; $display("FAIL sll_latency got=%0d exp=8", lat); end
   endtask

   task automatic test_sra_srl();
      logic [31:0] w = '0;
      logic [7:0]  lv = '0;
      int lat; bit to;
      start_req(4'b1101, 1'b0, 32'h8000_0000, 5'd31);
      collect(0, 8, 1'b0, w, lv, lat, to);
      checks++;
      if (to || w !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sra_word got=%h exp=ffffffff", w); end
      w = '0; lv = '0;
      start_req(4'b0101, 1'b0, 32'h8000_0000, 5'd31);
      collect(0, 8, 1'b0, w, lv, lat, to);
      checks++;
      if (to || w !== 32'h0000_0001) begin errors++; $display("FAIL srl_word got=%h exp=00000001", w); end
   endtask

   task automatic test_backpressure();
      logic [31:0] w = '0;
      logic [7:0]  lv = '0;
      int lat; bit to;
      start_req(4'b0101, 1'b0, 32'h1234_5678, 5'd0);
      collect(0, 2, 1'b0, w, lv, lat, to);
      out_ready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1;
         checks++;
         if (out_valid !== 1'b1 || out_data !== 4'h6 || out_last !== 1'b0) begin
            errors++;
            $display("FAIL bp_hold cyc=%0d valid=%0b data=%h last=%0b exp valid=1 data=6 last=0",
                     c, out_valid, out_data, out_last);
         end
         checks++;
         if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got=%0b exp=0", in_ready); end
         @(posedge clk); #1;
      end
      collect(2, 8, 1'b0, w, lv, lat, to);
      checks++;
      if (to || w !== 32'h1234_5678) begin errors++; $display("FAIL bp_word got=%h exp=12345678", w); end
      checks++;
      if (lat !== 6) begin errors++; $display("FAIL bp_remaining_cycles got=%0d exp=6", lat); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] w1 = '0;
      logic [31:0] w2 = '0;
      logic [7:0]  lv = '0;
      logic [3:0]  o1;
      logic [31:0] a1;
      logic [4:0]  b1;
      int lat; bit to;
      o1 = 4'($urandom) | 4'b0100;
      a1 = $urandom; b1 = 5'($urandom);
      start_req(o1, 1'b0, a1, b1);
      collect(0, 7, 1'b0, w1, lv, lat, to);
      checks++;
      if (out_valid !== 1'b1 || out_last !== 1'b1) begin
         errors++; $display("FAIL b2b_last_digit valid=%0b last=%0b exp 1 1", out_valid, out_last);
      end
      w1[31:28] = out_data;
      op = 4'b0001; rot = 1'b0; a = 32'hFFFF_FFFF; b = 5'd31; in_valid = 1'b1;
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%0b exp=1", in_ready); end
      @(posedge clk); #1;
      in_valid = 1'b0; a = $urandom; b = 5'($urandom);
      checks++;
      if (w1 !== ref_word(o1, 1'b0, a1, b1)) begin
         errors++; $display("FAIL b2b_word1 got=%h exp=%h", w1, ref_word(o1, 1'b0, a1, b1));
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== 4'h0 || out_last !== 1'b0) begin
         errors++; $display("FAIL b2b_no_gap valid=%0b data=%h last=%0b exp 1 0 0", out_valid, out_data, out_last);
      end
      lv = '0;
      collect(0, 8, 1'b0, w2, lv, lat, to);
      checks++;
      if (to || w2 !== 32'h8000_0000 || lat !== 8) begin
         errors++; $display("FAIL b2b_word2 got=%h lat=%0d exp=80000000 lat=8", w2, lat);
      end
   endtask

   task automatic test_reset_abort();
      logic [31:0] w = '0;
      logic [7:0]  lv = '0;
      logic [3:0]  o;
      logic [31:0] av;
      logic [4:0]  bv;
      int lat; bit to;
      start_req(4'b1101, 1'b0, 32'hDEAD_BEEF, 5'd7);
      collect(0, 4, 1'b0, w, lv, lat, to);
      rst = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++; $display("FAIL abort_state valid=%0b in_ready=%0b exp 0 1", out_valid, in_ready);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      o = 4'($urandom); av = $urandom; bv = 5'($urandom);
      w = '0; lv = '0;
      start_req(o, 1'b0, av, bv);
      collect(0, 8, 1'b0, w, lv, lat, to);
      checks++;
      if (to || w !== ref_word(o, 1'b0, av, bv) || lv !== 8'h80) begin
         errors++; $display("FAIL abort_fresh_word got=%h last=%b exp=%h", w, lv, ref_word(o, 1'b0, av, bv));
      end
   endtask

   task automatic test_rotate();
      logic [31:0] w = '0;
      logic [7:0]  lv = '0;
      logic [31:0] exp_w;
      int lat; bit to;
`ifdef NANOV_SHIFT_ROTATE_EN
      exp_w = 32'h8000_0000;
`else
      exp_w = 32'h0000_0000;
`endif
      start_req(4'b0101, 1'b1, 32'h0000_0001, 5'd1);
      collect(0, 8, 1'b0, w, lv, lat, to);
      checks++;
      if (to || w !== exp_w) begin errors++; $display("FAIL ror_word got=%h exp=%h", w, exp_w); end
   endtask

   task automatic test_random();
      for (int it = 0; it < 30; it++) begin
         logic [31:0] w = '0;
         logic [7:0]  lv = '0;
         logic [3:0]  o;
         logic        r;
         logic [31:0] av;
         logic [4:0]  bv;
         bit          stall;
         int lat; bit to;
         o = 4'($urandom); r = 1'($urandom); av = $urandom; bv = 5'($urandom);
         if (it < 4) bv = (it % 2 == 0) ? 5'd0 : 5'd31;
         stall = 1'($urandom);
         start_req(o, r, av, bv);
         collect(0, 8, stall, w, lv, lat, to);
         checks++;
         if (to || w !== ref_word(o, r, av, bv) || lv !== 8'h80) begin
            errors++;
            $display("FAIL rand_word it=%0d op=%b rot=%0b a=%h b=%0d got=%h last=%b exp=%h",
                     it, o, r, av, bv, w, lv, ref_word(o, r, av, bv));
         end
         if (!stall) begin
            checks++;
            if (lat !== 8) begin errors++; $display("FAIL rand_latency it=%0d got=%0d exp=8", it, lat); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_sll_vector();
      test_sra_srl();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      test_rotate();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
